serial_adder_subtractor: RTL



---
 rtl/serial_adder_subtractor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_adder_subtractor.sv
// Bit-serial unsigned adder/subtractor with request/response handshakes.
// Optional SERIAL_ADDSUB_OVF_EN adds a registered signed-overflow output (ovf).
module serial_adder_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             control,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] z,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, z_q, z_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sum_bit, maj_bit;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             cmsb_q, cmsb_d, ovf_q, ovf_d;
`endif

  assign sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
  assign maj_bit = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      z_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDSUB_OVF_EN
      cmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      z_q     <= z_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      cmsb_q  <= cmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    z_d       = z_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    cmsb_d    = cmsb_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          // Subtraction as x + ~y + 1: invert b and seed the carry with control.
          a_d     = x;
          b_d     = y ^ {WIDTH{control}};
          carry_d = control;
          res_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == CW'(WIDTH)) begin
          // Extra registration cycle after the last slice: publish the result.
          z_d     = res_q;
          cout_d  = carry_q;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = cmsb_q ^ carry_q;
`endif
          state_d = DONE;
        end else begin
          res_d   = {sum_bit, res_q[WIDTH-1:1]};
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          carry_d = maj_bit;
          cnt_d   = cnt_q + CW'(1);
`ifdef SERIAL_ADDSUB_OVF_EN
          if (cnt_q == CW'(WIDTH - 1)) cmsb_d = carry_q;
`endif
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign z    = z_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
